// File: rtl/cp0_unit_pkg.sv
// Shared CPU definitions for the CP0 unit: register addresses, SR/Cause field
// positions, exception codes and register image packing helpers.
package cp0_unit_pkg;

    typedef enum logic [4:0] {
        CP0_SR    = 5'd12,
        CP0_CAUSE = 5'd13,
        CP0_EPC   = 5'd14,
        CP0_PRID  = 5'd15
    } cp0_addr_e;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_BD_BIT  = 31;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] r;
        r = 32'h0000_0000;
        r[SR_IM_MSB:SR_IM_LSB] = im;
        r[SR_EXL_BIT]          = exl;
        r[SR_IE_BIT]           = ie;
        return r;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] r;
        r = 32'h0000_0000;
        r[CAUSE_BD_BIT]                = bd;
        r[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
        r[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc;
        return r;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// CP0 unit: SR/Cause/EPC, interrupt and exception request, mtc0/mfc0/eret.
// Optional PRId read at address 15 is enabled by defining CP0_PRID_EN.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] CP0Out,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req_s;
    logic        exc_req_s;
    logic        sr_wr_s;
    logic        epc_wr_s;

    // Request decode; EXL masks both sources so exceptions never nest.
    always_comb begin
        int_req_s = (|(HWInt & im_q)) & ie_q & ~exl_q;
        exc_req_s = (ExcCodeIn != 5'd0) & ~exl_q;
        Req       = int_req_s | exc_req_s;
        sr_wr_s   = en & (CP0Add == CP0_SR);
        epc_wr_s  = en & (CP0Add == CP0_EPC);
    end

    // Next-state: reset, then exception entry, then mtc0/eret updates.
    always_comb begin
        im_d  = im_q;
        exl_d = exl_q & ~EXLClr;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = HWInt;
        exc_d = exc_q;
        epc_d = epc_q;
        if (reset) begin
            im_d  = 6'd0;
            exl_d = 1'b0;
            ie_d  = 1'b0;
            bd_d  = 1'b0;
            ip_d  = 6'd0;
            exc_d = 5'd0;
            epc_d = 32'h0000_0000;
        end else if (Req) begin
            // Interrupt takes priority over a simultaneous exception code.
            exl_d = 1'b1;
            bd_d  = BDIn;
            exc_d = int_req_s ? EXC_INT : ExcCodeIn;
            epc_d = BDIn ? (VPC - 32'd4) : VPC;
        end else if (sr_wr_s) begin
            im_d  = CP0In[SR_IM_MSB:SR_IM_LSB];
            ie_d  = CP0In[SR_IE_BIT];
            exl_d = CP0In[SR_EXL_BIT] & ~EXLClr;
        end else if (epc_wr_s) begin
            epc_d = CP0In;
        end else begin
            epc_d = epc_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        im_q  <= im_d;
        exl_q <= exl_d;
        ie_q  <= ie_d;
        bd_q  <= bd_d;
        ip_q  <= ip_d;
        exc_q <= exc_d;
        epc_q <= epc_d;
    end

    assign EPCOut = epc_q;

`ifdef CP0_PRID_EN
    // mfc0 read mux including the processor ID constant.
    always_comb begin
        case (CP0Add)
            CP0_SR:    CP0Out = pack_sr(im_q, exl_q, ie_q);
            CP0_CAUSE: CP0Out = pack_cause(bd_q, ip_q, exc_q);
            CP0_EPC:   CP0Out = epc_q;
            CP0_PRID:  CP0Out = PRID_VALUE;
            default:   CP0Out = 32'h0000_0000;
        endcase
    end
`else
    logic unused_prid_s;
    assign unused_prid_s = ^PRID_VALUE;

    // mfc0 read mux; address 15 falls through to zero.
    always_comb begin
        case (CP0Add)
            CP0_SR:    CP0Out = pack_sr(im_q, exl_q, ie_q);
            CP0_CAUSE: CP0Out = pack_cause(bd_q, ip_q, exc_q);
            CP0_EPC:   CP0Out = epc_q;
            default:   CP0Out = 32'h0000_0000;
        endcase
    end
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Directed scoreboard bench for cp0_unit: expectations are queued as stimulus
// is applied and popped when the matching output is sampled.
module tb_cp0_unit;
    import cp0_unit_pkg::*;

    localparam logic [31:0] PRID = 32'hC0DE_0001;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  CP0Add;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic        Req;

    cp0_unit #(.PRID_VALUE(PRID)) dut (
        .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In),
        .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .CP0Out(CP0Out), .EPCOut(EPCOut), .Req(Req)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty got=%h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s got=%h exp=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] v);
        CP0Add = addr;
        push(tag, v);
        #1;
        chk(CP0Out);
    endtask

    task automatic req_chk(input string tag, input logic v);
        push(tag, {31'h0, v});
        #1;
        chk({31'h0, Req});
    endtask

    task automatic epc_chk(input string tag, input logic [31:0] v);
        push(tag, v);
        #1;
        chk(EPCOut);
    endtask

    task automatic idle();
        reset = 1'b0; en = 1'b0; CP0Add = 5'd0; CP0In = 32'h0; VPC = 32'h0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        idle();
    endtask

    logic [31:0] prid_exp;

    initial begin
`ifdef CP0_PRID_EN
        prid_exp = PRID;
`else
        prid_exp = 32'h0000_0000;
`endif
        idle();
        // Reset with interrupt lines high: IP must still clear.
        reset = 1'b1;
        HWInt = 6'h3F;
        @(negedge clk);
        next();
        rd(CP0_SR, "rst_sr", 32'h0000_0000);
        rd(CP0_CAUSE, "rst_cause", 32'h0000_0000);
        rd(CP0_EPC, "rst_epc", 32'h0000_0000);
        epc_chk("rst_epcout", 32'h0000_0000);
        req_chk("rst_req", 1'b0);
        en = 1'b1; CP0Add = CP0_SR; CP0In = 32'h0000_FC01;
        req_chk("mtc0_sr_req", 1'b0);

        next();
        rd(CP0_SR, "sr_written", 32'h0000_FC01);
        HWInt = 6'b000001; VPC = 32'h0000_1000;
        req_chk("int_req", 1'b1);

        next();
        rd(CP0_SR, "int_sr_exl", 32'h0000_FC03);
        rd(CP0_CAUSE, "int_cause", 32'h0000_0400);
        rd(CP0_EPC, "int_epc", 32'h0000_1000);
        epc_chk("int_epcout", 32'h0000_1000);
        HWInt = 6'b000010; ExcCodeIn = EXC_ADEL; VPC = 32'h0000_5550;
        req_chk("exl_blocks_req", 1'b0);

        next();
        rd(CP0_CAUSE, "ip_only_update", 32'h0000_0800);
        rd(CP0_SR, "exl_sr_hold", 32'h0000_FC03);
        rd(CP0_EPC, "exl_epc_hold", 32'h0000_1000);
        EXLClr = 1'b1;
        req_chk("eret_req", 1'b0);

        next();
        rd(CP0_SR, "eret_sr", 32'h0000_FC01);
        ExcCodeIn = EXC_OV; BDIn = 1'b1; VPC = 32'h0000_3010;
        req_chk("ov_req", 1'b1);

        next();
        rd(CP0_CAUSE, "ov_cause", 32'h8000_0030);
        rd(CP0_EPC, "ov_epc_bd", 32'h0000_300C);
        rd(CP0_SR, "ov_sr", 32'h0000_FC03);
        EXLClr = 1'b1; en = 1'b1; CP0Add = CP0_SR; CP0In = 32'hFFFF_FFFF;
        req_chk("eret_mtc0_req", 1'b0);

        next();
        rd(CP0_SR, "eret_mtc0_sr", 32'h0000_FC01);
        EXLClr = 1'b1; ExcCodeIn = EXC_RI; VPC = 32'h0000_2000;
        en = 1'b1; CP0Add = CP0_EPC; CP0In = 32'hDEAD_BEEF;
        req_chk("ri_eret_req", 1'b1);

        next();
        rd(CP0_SR, "ri_sr", 32'h0000_FC03);
        rd(CP0_CAUSE, "ri_cause", 32'h0000_0028);
        rd(CP0_EPC, "ri_mtc0_suppressed", 32'h0000_2000);
        EXLClr = 1'b1;
        req_chk("eret2_req", 1'b0);

        next();
        rd(CP0_SR, "eret2_sr", 32'h0000_FC01);
        HWInt = 6'b100000; ExcCodeIn = EXC_ADES; VPC = 32'h0000_3000;
        req_chk("int_exc_req", 1'b1);

        next();
        rd(CP0_CAUSE, "int_wins_cause", 32'h0000_8000);
        rd(CP0_EPC, "int_wins_epc", 32'h0000_3000);
        EXLClr = 1'b1;
        req_chk("eret3_req", 1'b0);

        next();
        en = 1'b1; CP0Add = CP0_EPC; CP0In = 32'h0000_4180;
        epc_chk("epcout_no_bypass", 32'h0000_3000);
        req_chk("mtc0_epc_req", 1'b0);

        next();
        rd(CP0_EPC, "mtc0_epc_rd", 32'h0000_4180);
        epc_chk("mtc0_epcout", 32'h0000_4180);
        rd(CP0_PRID, "prid_rd", prid_exp);
        rd(CP0_CAUSE, "cause_pre", 32'h0000_0000);
        en = 1'b1; CP0Add = CP0_CAUSE; CP0In = 32'hFFFF_FFFF;
        req_chk("mtc0_cause_req", 1'b0);

        next();
        rd(CP0_CAUSE, "cause_not_writable", 32'h0000_0000);
        rd(5'd3, "unimpl_rd", 32'h0000_0000);
        en = 1'b1; CP0Add = CP0_SR; CP0In = 32'h0000_FC00;
        req_chk("sr_ie0_wr_req", 1'b0);

        next();
        HWInt = 6'b000001;
        req_chk("ie0_masks", 1'b0);
        HWInt = 6'b000000;
        en = 1'b1; CP0Add = CP0_SR; CP0In = 32'h0000_0401;
        req_chk("sr_im0_wr_req", 1'b0);

        next();
        rd(CP0_SR, "sr_im0", 32'h0000_0401);
        HWInt = 6'b000010;
        req_chk("im_masks", 1'b0);
        HWInt = 6'b000001;
        req_chk("im_pass", 1'b1);
        HWInt = 6'b000000;

        // Reset overrides a pending exception and an mtc0 write.
        @(negedge clk);
        idle();
        reset = 1'b1; ExcCodeIn = EXC_OV; en = 1'b1; CP0Add = CP0_EPC; CP0In = 32'hFFFF_FFFF;
        EXLClr = 1'b1; HWInt = 6'h3F;
        next();
        rd(CP0_SR, "rst2_sr", 32'h0000_0000);
        rd(CP0_CAUSE, "rst2_cause", 32'h0000_0000);
        rd(CP0_EPC, "rst2_epc", 32'h0000_0000);
        req_chk("rst2_req", 1'b0);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have parameter PRID_VALUE, default 32'h0000_0000, constant returned on PRId read (address 15).
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  mtc0 write enable from the M stage.
REQ-005 SHALL have port CP0Add  input  5  register address for mtc0 write and mfc0 read.
REQ-006 SHALL have port CP0In  input  32  mtc0 write data.
REQ-007 SHALL have port VPC  input  32  PC of the M-stage instruction (victim PC).
REQ-008 SHALL have port BDIn  input  1  M-stage instruction is in a branch delay slot.
REQ-009 SHALL have port ExcCodeIn  input  5  exception code; 0 means none.
REQ-010 SHALL have port HWInt  input  6  external hardware interrupt lines.
REQ-011 SHALL have port EXLClr  input  1  eret in M stage; clear SR.EXL.
REQ-012 SHALL have port CP0Out  output  32  mfc0 read data, feeds M_CP0Out of the M/W register.
REQ-013 SHALL have port EPCOut  output  32  current EPC, eret target.
REQ-014 SHALL have port Req  output  1  exception/interrupt taken; flushes pipeline and W-stage register.

Function
REQ-015 SR(12) SHALL implement only IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-016 Cause(13) SHALL implement BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0; not writable by mtc0.
REQ-017 EPC(14) SHALL be a full 32-bit register.
REQ-018 IntReq SHALL be combinational: |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
REQ-019 ExcReq SHALL be combinational: (ExcCodeIn != 0) & ~SR.EXL.
REQ-020 Req SHALL equal IntReq | ExcReq, combinational, same cycle; no latency.
REQ-021 On posedge with Req=1: EXL<=1; Cause.BD<=BDIn; Cause.ExcCode<=IntReq ? 0 : ExcCodeIn (interrupt wins); EPC<=BDIn ? VPC-4 : VPC.
REQ-022 Cause.IP SHALL load HWInt every cycle, independent of Req, en, EXL.
REQ-023 mtc0 with en=1 and Req=0 SHALL write SR (IM/EXL/IE fields only) or EPC per CP0Add; other addresses ignored.
REQ-024 en=1 with Req=1 SHALL be suppressed; exception update only.
REQ-025 EXLClr=1 with Req=0 SHALL clear EXL at next edge; with Req=1, Req wins and EXL stays 1.
REQ-026 EXLClr with en writing SR in the same cycle SHALL leave EXL=0; remaining SR fields take CP0In.
REQ-027 CP0Out SHALL combinationally return the addressed register's pre-edge value; unimplemented addresses return 0.
REQ-028 EPCOut SHALL equal registered EPC; no bypass of same-cycle writes.
REQ-029 While EXL=1, no new Req SHALL be raised (nesting disabled).

Reset
REQ-030 reset=1 SHALL clear SR, Cause and EPC to 0 at next posedge; Req is 0 in the following cycle.
REQ-031 reset SHALL override Req, en and EXLClr in the same cycle.

Configuration
REQ-032 With CP0_PRID_EN defined, address 15 SHALL read PRID_VALUE; without it, address 15 SHALL read 0 and no PRId logic is present.

Structure
REQ-033 Register addresses (12/13/14/15), SR/Cause field bit positions and ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12) SHALL live in the shared CPU package.
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 Reset, then mtc0 SR=32'h0000_FC01, HWInt=6'b000001 -> Req=1 same cycle; next: EXL=1, ExcCode=0, EPC=VPC.
REQ-036 ExcCodeIn=12, BDIn=1, VPC=32'h0000_3010 -> Req=1; Cause=32'h8000_0030 (IP=0), EPC=32'h0000_300C.
REQ-037 EXL=1 with HWInt active and ExcCodeIn=4 -> Req=0, all registers unchanged except IP.
REQ-038 EXLClr=1 and ExcCodeIn=10 in same cycle (EXL=0 beforehand) -> Req=1, EXL=1, ExcCode=10.
REQ-039 mtc0 CP0Add=14, CP0In=32'h0000_4180 -> CP0Out on address 14 reads 32'h0000_4180 next cycle; EPCOut matches; read address 15 -> PRID_VALUE or 0 per CP0_PRID_EN.
